// File: rtl/mc_control_fsm_pkg.sv
// Shared constants for the multicycle MIPS control unit: state codes, opcode and funct
// values, ALU op codes, mux selects and the control word struct.
package mc_control_fsm_pkg;

    localparam int OP_W     = 6;
    localparam int ALU_OP_W = 2;
    localparam int STATE_W  = 4;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_ALU_WB    = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EX   = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_load;
        logic [1:0] pc_src;
    } ctrl_t;

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct field to ALU op select; flags funct values the ALU does not support.
module mc_alu_decoder
    import mc_control_fsm_pkg::*;
(
    input  logic [OP_W-1:0]     funct,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal_funct
);

    always_comb begin
        alu_op        = ALU_ADD;
        illegal_funct = 1'b0;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            default: illegal_funct = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: state register, next-state logic and Moore output decode
// driving the datapath muxes/enables and the ALU op select.
//
// state     | meaning
// ----------+------------------------------------------------
// FETCH     | read instruction, load IR, PC <= PC + 4
// DECODE    | branch target into ALUOut, dispatch on opcode
// MEM_ADDR  | compute lw/sw effective address
// MEM_READ  | read data memory into MDR
// MEM_WB    | write MDR to rt
// MEM_WRITE | write B to data memory
// EXECUTE   | R-type ALU operation
// ALU_WB    | write ALUOut to rd
// BRANCH    | compare A - B, take branch on zero
// JUMP      | load jump target into PC
// ADDI_EX   | A + sext(imm)
// ADDI_WB   | write ALUOut to rt
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int OP_WIDTH     = 6,
    parameter int ALU_OP_WIDTH = 2,
    parameter int STATE_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OP_WIDTH-1:0]     opcode,
    input  logic [OP_WIDTH-1:0]     funct,
    input  logic                    zero,
    output logic                    pc_en,
    output logic                    iord,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    ir_write,
    output logic                    reg_dst,
    output logic                    mem_to_reg,
    output logic                    reg_write,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [ALU_OP_WIDTH-1:0] alu_load,
    output logic [1:0]              pc_src,
    output logic                    illegal,
    output logic [STATE_WIDTH-1:0]  state
);

    logic [3:0]    state_q;
    logic [3:0]    state_nxt;
    logic          mem_is_sw;
    logic [1:0]    funct_alu_op;
    logic          illegal_funct;
    logic          opcode_bad;
    ctrl_t         ctrl;

    mc_alu_decoder u_alu_decoder (
        .funct         (funct),
        .alu_op        (funct_alu_op),
        .illegal_funct (illegal_funct)
    );

    always_comb begin
        opcode_bad = 1'b0;
        case (opcode)
            OP_RTYPE: opcode_bad = illegal_funct;
            OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: opcode_bad = 1'b0;
            default:  opcode_bad = 1'b1;
        endcase
    end

    // lw/sw is captured in DECODE so MEM_ADDR never looks at the opcode again.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            mem_is_sw <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (state_q == S_DECODE) begin
                mem_is_sw <= (opcode == OP_SW);
            end
        end
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state_q)
            S_FETCH:     state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: state_nxt = illegal_funct ? S_FETCH : S_EXECUTE;
                    OP_LW:    state_nxt = S_MEM_ADDR;
                    OP_SW:    state_nxt = S_MEM_ADDR;
                    OP_BEQ:   state_nxt = S_BRANCH;
                    OP_J:     state_nxt = S_JUMP;
                    OP_ADDI:  state_nxt = S_ADDI_EX;
                    default:  state_nxt = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_nxt = mem_is_sw ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_nxt = S_MEM_WB;
            S_EXECUTE:   state_nxt = S_ALU_WB;
            S_ADDI_EX:   state_nxt = S_ADDI_WB;
            default:     state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_load  = ALU_ADD;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_load  = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_load  = ALU_ADD;
            end
            S_MEM_READ: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_load  = funct_alu_op;
            end
            S_ALU_WB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_load  = ALU_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            S_ADDI_WB: ctrl.reg_write = 1'b1;
            default:   ctrl = '0;
        endcase
    end

    // Write enables are held off for the whole reset window, not just after the first edge.
    assign pc_en      = ~rst & (ctrl.pc_write | (ctrl.branch & zero));
    assign ir_write   = ~rst & ctrl.ir_write;
    assign mem_write  = ~rst & ctrl.mem_write;
    assign reg_write  = ~rst & ctrl.reg_write;
    assign illegal    = ~rst & (state_q == S_DECODE) & opcode_bad;
    assign iord       = ctrl.iord;
    assign mem_read   = ctrl.mem_read;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_load   = ctrl.alu_load;
    assign pc_src     = ctrl.pc_src;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class, the illegal paths
// and a mid-instruction reset, checking state and control outputs at each step.
module tb_mc_control_fsm;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_load;
    logic [1:0] pc_src;
    logic       illegal;
    logic [3:0] state;

    int vectors;
    int miscompares;

    mc_control_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_load   (alu_load),
        .pc_src     (pc_src),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        opcode = 6'h00;
        funct  = 6'h20;
        zero   = 1'b0;

        // reset held for two edges
        step();
        chk("rst1_state", 8'(state), 8'd0);
        chk("rst1_pc_en", 8'(pc_en), 8'd0);
        chk("rst1_ir_write", 8'(ir_write), 8'd0);
        chk("rst1_reg_write", 8'(reg_write), 8'd0);
        chk("rst1_mem_write", 8'(mem_write), 8'd0);
        step();
        chk("rst2_state", 8'(state), 8'd0);
        chk("rst2_pc_en", 8'(pc_en), 8'd0);
        rst = 1'b0;
        #1;
        chk("fetch_pc_en", 8'(pc_en), 8'd1);
        chk("fetch_ir_write", 8'(ir_write), 8'd1);
        chk("fetch_mem_read", 8'(mem_read), 8'd1);
        chk("fetch_src_b", 8'(alu_src_b), 8'd1);

        // R-type sub
        opcode = 6'h00;
        funct  = 6'h22;
        step();
        chk("r_decode_state", 8'(state), 8'd1);
        chk("r_decode_src_b", 8'(alu_src_b), 8'd3);
        chk("r_decode_illegal", 8'(illegal), 8'd0);
        step();
        chk("r_exec_state", 8'(state), 8'd6);
        chk("r_exec_alu_load", 8'(alu_load), 8'd1);
        chk("r_exec_src_a", 8'(alu_src_a), 8'd1);
        chk("r_exec_src_b", 8'(alu_src_b), 8'd0);
        step();
        chk("r_wb_state", 8'(state), 8'd7);
        chk("r_wb_reg_write", 8'(reg_write), 8'd1);
        chk("r_wb_reg_dst", 8'(reg_dst), 8'd1);
        step();
        chk("r_done_state", 8'(state), 8'd0);

        // lw; opcode scrambled after DECODE must not redirect it to MEM_WRITE
        opcode = 6'h23;
        step();
        chk("lw_decode_state", 8'(state), 8'd1);
        step();
        chk("lw_addr_state", 8'(state), 8'd2);
        chk("lw_addr_src_b", 8'(alu_src_b), 8'd2);
        opcode = 6'h2B;
        step();
        chk("lw_read_state", 8'(state), 8'd3);
        chk("lw_read_iord", 8'(iord), 8'd1);
        chk("lw_read_mem_read", 8'(mem_read), 8'd1);
        step();
        chk("lw_wb_state", 8'(state), 8'd4);
        chk("lw_wb_mem_to_reg", 8'(mem_to_reg), 8'd1);
        chk("lw_wb_reg_write", 8'(reg_write), 8'd1);
        step();
        chk("lw_done_state", 8'(state), 8'd0);

        // sw
        opcode = 6'h2B;
        step();
        step();
        chk("sw_addr_state", 8'(state), 8'd2);
        step();
        chk("sw_write_state", 8'(state), 8'd5);
        chk("sw_mem_write", 8'(mem_write), 8'd1);
        chk("sw_iord", 8'(iord), 8'd1);
        step();
        chk("sw_done_state", 8'(state), 8'd0);

        // beq: zero only matters in BRANCH
        opcode = 6'h04;
        zero   = 1'b1;
        step();
        chk("beq_decode_pc_en", 8'(pc_en), 8'd0);
        step();
        chk("beq_branch_state", 8'(state), 8'd8);
        chk("beq_taken_pc_en", 8'(pc_en), 8'd1);
        chk("beq_pc_src", 8'(pc_src), 8'd1);
        chk("beq_alu_load", 8'(alu_load), 8'd1);
        zero = 1'b0;
        #1;
        chk("beq_not_taken_pc_en", 8'(pc_en), 8'd0);
        step();
        chk("beq_done_state", 8'(state), 8'd0);

        // j
        opcode = 6'h02;
        step();
        step();
        chk("j_state", 8'(state), 8'd9);
        chk("j_pc_en", 8'(pc_en), 8'd1);
        chk("j_pc_src", 8'(pc_src), 8'd2);
        step();
        chk("j_done_state", 8'(state), 8'd0);

        // addi
        opcode = 6'h08;
        step();
        step();
        chk("addi_ex_state", 8'(state), 8'd10);
        chk("addi_ex_src_b", 8'(alu_src_b), 8'd2);
        step();
        chk("addi_wb_state", 8'(state), 8'd11);
        chk("addi_wb_reg_write", 8'(reg_write), 8'd1);
        chk("addi_wb_reg_dst", 8'(reg_dst), 8'd0);
        step();
        chk("addi_done_state", 8'(state), 8'd0);

        // illegal opcode
        opcode = 6'h3F;
        step();
        chk("badop_illegal", 8'(illegal), 8'd1);
        chk("badop_reg_write", 8'(reg_write), 8'd0);
        step();
        chk("badop_next_state", 8'(state), 8'd0);
        chk("badop_illegal_clear", 8'(illegal), 8'd0);

        // illegal R-type funct
        opcode = 6'h00;
        funct  = 6'h27;
        step();
        chk("badfn_illegal", 8'(illegal), 8'd1);
        chk("badfn_mem_write", 8'(mem_write), 8'd0);
        step();
        chk("badfn_next_state", 8'(state), 8'd0);

        // reset during MEM_READ of lw
        opcode = 6'h23;
        funct  = 6'h20;
        step();
        step();
        step();
        chk("rstmid_read_state", 8'(state), 8'd3);
        rst = 1'b1;
        step();
        chk("rstmid_state", 8'(state), 8'd0);
        chk("rstmid_reg_write", 8'(reg_write), 8'd0);
        rst = 1'b0;
        #1;
        chk("rstmid_ir_write", 8'(ir_write), 8'd1);
        step();
        chk("rstmid_decode_state", 8'(state), 8'd1);
        chk("rstmid_decode_reg_write", 8'(reg_write), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
